// File: rtl/rv32_pkg.sv
// rv32_pkg: shared rv32 pipeline types and constants.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;
endpackage

// File: rtl/ifetch_pc_gen.sv
// ifetch_pc_gen: next-PC/next-state priority (redirect > halt > stall > +4).
// FETCH_MISALIGN_CHK_EN: misaligned redirect targets raise an error and halt.
module ifetch_pc_gen
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input  fetch_state_e    state,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output fetch_state_e    state_nxt,
  output logic [XLEN-1:0] pc_nxt,
  output logic            cap,
  output logic            kill,
  output logic            err_set
);
  logic            mis;
  logic [XLEN-1:0] tgt;
`ifdef FETCH_MISALIGN_CHK_EN
  assign mis = |redirect_pc[1:0];
`else
  assign mis = 1'b0;
`endif
  assign tgt = redirect_pc & ~32'h3;
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap       = 1'b0;
    kill      = 1'b0;
    err_set   = 1'b0;
    if (state == IDLE) begin
      pc_nxt    = RESET_VEC;
      state_nxt = RUN;
    end else if (redirect) begin
      kill      = 1'b1;
      err_set   = mis;
      pc_nxt    = mis ? pc : tgt;
      state_nxt = mis ? HALT : RUN;
    end else if (state == RUN) begin
      if (halt) begin
        kill      = 1'b1;
        state_nxt = HALT;
      end else if (!stall) begin
        cap    = 1'b1;
        pc_nxt = pc + 32'd4;
      end
    end
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: rv32 instruction-fetch stage owning the PC and the IF/ID register.
// FETCH_MISALIGN_CHK_EN: enables the sticky misaligned-redirect error.
module ifetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
  parameter int              IMEM_DEPTH = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_data,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc_plus4,
  output logic [XLEN-1:0] o_id_instr,
  output logic            o_fetch_err
);
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            cap, kill, err_set, err;
  ifid_t           ifid;

  ifetch_pc_gen #(.RESET_VEC(RESET_VEC)) u_pc_gen (
    .state       (state),
    .pc          (pc),
    .stall       (i_stall),
    .redirect    (i_redirect),
    .redirect_pc (i_redirect_pc),
    .halt        (i_halt),
    .state_nxt   (state_nxt),
    .pc_nxt      (pc_nxt),
    .cap         (cap),
    .kill        (kill),
    .err_set     (err_set)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      pc    <= RESET_VEC;
      err   <= 1'b0;
      ifid  <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      err   <= err | err_set;
      if (cap)
        ifid <= '{valid: 1'b1, pc: pc, pc_plus4: pc + 32'd4, instr: i_imem_data};
      else if (kill) begin
        ifid.valid <= 1'b0;
        ifid.instr <= NOP_INSTR;
      end
    end

  // Word index wraps modulo the memory depth.
  assign o_imem_addr   = (pc >> 2) & 32'(IMEM_DEPTH - 1);
  assign o_id_valid    = ifid.valid;
  assign o_id_pc       = ifid.pc;
  assign o_id_pc_plus4 = ifid.pc_plus4;
  assign o_id_instr    = ifid.instr;
  assign o_fetch_err   = err;
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the rv32 pipeline. It owns the program counter, drives the word-indexed instruction memory address, captures the returned instruction into the IF/ID pipeline register, and honours stall, redirect and halt requests from downstream. The instruction memory read is combinational, so each fetch completes in the same cycle it is issued.

## Interface
- RESET_VEC, 32'h0000_0000: byte address of the first fetched instruction.
- IMEM_DEPTH, 1024: instruction memory depth in 32-bit words; must be a power of two.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_stall  in  1  hazard unit: hold PC and IF/ID contents.
- i_redirect  in  1  EX stage: branch taken or jump; load i_redirect_pc.
- i_redirect_pc  in  32  redirect target, byte address.
- i_halt  in  1  stop fetching (ecall/ebreak/testbench).
- o_imem_addr  out  32  word index into instruction memory.
- i_imem_data  in  32  instruction word, valid combinationally from o_imem_addr.
- o_id_valid  out  1  IF/ID register holds a real instruction.
- o_id_pc  out  32  byte PC of o_id_instr.
- o_id_pc_plus4  out  32  o_id_pc + 4.
- o_id_instr  out  32  fetched instruction; 32'h0000_0013 (NOP) when not valid.
- o_fetch_err  out  1  sticky misaligned-target flag.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE: one cycle, no fetch, pc = RESET_VEC; unconditionally advances to RUN.
- RUN: o_imem_addr = {2'b0, pc[31:2]} & (IMEM_DEPTH-1); addresses wrap modulo IMEM_DEPTH words.
- RUN, no stall/redirect: IF/ID <= {valid=1, pc, pc+4, i_imem_data}; pc <= pc + 4 (32-bit, wraps 0xFFFF_FFFC -> 0).
- i_stall: pc and IF/ID unchanged.
- i_redirect: pc <= i_redirect_pc; IF/ID valid <= 0, instr <= NOP (flush of the wrong-path fetch). Redirect wins over stall when both are asserted.
- i_halt in RUN (no redirect): go to HALT; IF/ID valid <= 0. Redirect wins over halt in the same cycle.
- HALT: pc frozen, o_id_valid 0; i_redirect returns to RUN at the target; i_stall ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and any in-flight IF/ID contents are discarded.

## Timing
- Reset values: o_id_valid 0, o_id_pc 0, o_id_pc_plus4 0, o_id_instr 32'h0000_0013, o_fetch_err 0, pc RESET_VEC, o_imem_addr from RESET_VEC.
- Cycle numbering from the first rising edge after i_rst_n rises: edge 1 leaves IDLE; edge 2 captures RESET_VEC; o_id_valid is first high after edge 2.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction per cycle when not stalled.
- Redirect penalty: 1 bubble (the cycle the redirect edge occurs); the target instruction is valid on the following edge.
- i_stall, i_redirect and i_halt are sampled on the rising edge; o_imem_addr changes only after pc changes.

## Configuration
- FETCH_MISALIGN_CHK_EN defined: a redirect with i_redirect_pc[1:0] != 0 sets o_fetch_err (sticky until reset), enters HALT, and leaves pc unchanged.
- Not defined: i_redirect_pc[1:0] is forced to 0 and the redirect proceeds; o_fetch_err is tied 0.

## Structure
- Shared package rv32_pkg holds XLEN = 32, NOP_INSTR = 32'h0000_0013, the fetch state enum {IDLE, RUN, HALT}, and the IF/ID bundle typedef.
- One natural sub-module: ifetch_pc_gen, which handles next-PC priority (redirect > halt > stall > +4) and misalignment detection. The IF/ID register stays in ifetch.

## Test plan
- Reset release, memory words 0..2 = 0x0015_8593, 0x0, 0x0 -> o_id_valid first high after edge 2, o_id_pc 0, o_id_instr 0x0015_8593; then pc 4, 8 on successive cycles.
- i_stall held 3 cycles at pc 8 -> o_id_pc stays 4 and o_imem_addr stays 2 for 3 cycles; resumes at 8.
- Redirect to 0x40 with stall also asserted -> next cycle o_id_valid 0 and instr NOP; following cycle o_id_pc 0x40, o_imem_addr 0x10.
- i_halt at pc 0xC -> o_id_valid 0 and pc frozen; redirect to 0x0 -> RUN, o_id_pc 0 one cycle later.
- Redirect to 0x42 -> with the macro: o_fetch_err 1, HALT; without it: fetch proceeds from 0x40, o_fetch_err 0.
- IMEM_DEPTH 1024, redirect to 0x1000 -> o_imem_addr 0 (wrap); i_rst_n pulsed low mid-run -> outputs return to reset values asynchronously.
